// File: rtl/wb_stage_pkg.sv
// Shared definitions for the write-back stage: bus widths, CP0 register
// addresses, exception codes and the memory-to-write-back bus layout.
package wb_stage_pkg;

  localparam int MS_TO_WS_BUS_WD   = 124;
  localparam int WS_FWD_BLK_BUS_WD = 41;

  // CP0 register addresses encoded as {rd, sel}
  localparam logic [7:0] CP0_STATUS   = 8'h60;
  localparam logic [7:0] CP0_CAUSE    = 8'h68;
  localparam logic [7:0] CP0_EPC      = 8'h70;
  localparam logic [7:0] CP0_BADVADDR = 8'h40;
  localparam logic [7:0] CP0_COUNT    = 8'h48;
  localparam logic [7:0] CP0_COMPARE  = 8'h58;

  // Exception codes
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Memory stage to write-back stage bus, MSB first
  typedef struct packed {
    logic [4:0]  excode;
    logic [31:0] badvaddr;
    logic [7:0]  cp0_addr;
    logic        ex;
    logic        bd;
    logic        eret;
    logic        syscall;
    logic        mfc0;
    logic        mtc0;
    logic [3:0]  gr_strb;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } ms_to_ws_t;

  // Address-error exceptions are the only ones that capture BadVAddr
  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/wb_stage_cp0_regs.sv
// CP0 register set: Status, Cause, EPC, BadVAddr, Count, Compare.
// Handles mtc0 writes, exception/eret commit updates, the Count/Compare
// timer interrupt and the mfc0 read mux.
module cp0_regs
  import wb_stage_pkg::*;
#(
  parameter int INT_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mtc0_we_i,
  input  logic [7:0]           addr_i,
  input  logic [31:0]          wdata_i,
  output logic [31:0]          rdata_o,
  input  logic                 ex_i,
  input  logic [4:0]           excode_i,
  input  logic                 bd_i,
  input  logic [31:0]          pc_i,
  input  logic [31:0]          badvaddr_i,
  input  logic                 eret_i,
  input  logic [INT_WIDTH-1:0] ext_int_i,
  output logic [31:0]          epc_o,
  output logic                 int_pending_o
);

  logic [7:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic        ti_q, ti_d;
  logic [5:0]  ip_hw_q, ip_hw_d;
  logic [1:0]  ip_sw_q, ip_sw_d;
  logic [4:0]  exccode_q, exccode_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        tick_q, tick_d;

  logic [7:0]  ip;
  logic [31:0] status_rd;
  logic [31:0] cause_rd;

  // Assemble architectural views of Status and Cause
  always_comb begin
    ip        = {ip_hw_q[5] | ti_q, ip_hw_q[4:0], ip_sw_q};
    status_rd = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
    cause_rd  = {bd_q, ti_q, 14'd0, ip, 1'b0, exccode_q, 2'b00};
  end

  // mfc0 read mux; unimplemented addresses read as zero
  always_comb begin
    rdata_o = '0;
    case (addr_i)
      CP0_STATUS:   rdata_o = status_rd;
      CP0_CAUSE:    rdata_o = cause_rd;
      CP0_EPC:      rdata_o = epc_q;
      CP0_BADVADDR: rdata_o = badvaddr_q;
      CP0_COUNT:    rdata_o = count_q;
      CP0_COMPARE:  rdata_o = compare_q;
      default:      rdata_o = '0;
    endcase
  end

  // Next-state: mtc0 first, then eret, then exception so commit events win
  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_sw_d    = ip_sw_q;
    exccode_d  = exccode_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    compare_d  = compare_q;
    tick_d     = ~tick_q;
    ip_hw_d    = 6'(ext_int_i);
    count_d    = tick_q ? count_q + 32'd1 : count_q;
    ti_d       = ti_q | (count_q == compare_q);

    if (mtc0_we_i) begin
      case (addr_i)
        CP0_STATUS: begin
          im_d  = wdata_i[15:8];
          exl_d = wdata_i[1];
          ie_d  = wdata_i[0];
        end
        CP0_CAUSE:   ip_sw_d = wdata_i[9:8];
        CP0_EPC:     epc_d   = wdata_i;
        CP0_COUNT:   count_d = wdata_i;
        CP0_COMPARE: begin
          compare_d = wdata_i;
          ti_d      = 1'b0;
        end
        default: ;
      endcase
    end

    if (eret_i) begin
      exl_d = 1'b0;
    end

    if (ex_i) begin
      exl_d     = 1'b1;
      exccode_d = excode_i;
      if (!exl_q) begin
        epc_d = bd_i ? pc_i - 32'd4 : pc_i;
        bd_d  = bd_i;
      end
      if (is_addr_exc(excode_i)) begin
        badvaddr_d = badvaddr_i;
      end
    end
  end

  // CP0 state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ti_q       <= 1'b0;
      ip_hw_q    <= '0;
      ip_sw_q    <= '0;
      exccode_q  <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
      count_q    <= '0;
      compare_q  <= '0;
      tick_q     <= 1'b0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ti_q       <= ti_d;
      ip_hw_q    <= ip_hw_d;
      ip_sw_q    <= ip_sw_d;
      exccode_q  <= exccode_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      tick_q     <= tick_d;
    end
  end

  // Status-visible outputs
  always_comb begin
    epc_o         = epc_q;
    int_pending_o = (|(ip & im_q)) & ie_q & ~exl_q;
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: pipeline register, register-file commit, forward bus,
// debug trace and exception/eret flush with redirect PC.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter logic [31:0] EX_ENTRY  = 32'hBFC0_0380,
  parameter int          INT_WIDTH = 6
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ms_to_ws_valid,
  input  logic [MS_TO_WS_BUS_WD-1:0]   ms_to_ws_bus,
  output logic                         ws_allowin,
  input  logic [INT_WIDTH-1:0]         ext_int_in,
  output logic [3:0]                   rf_we,
  output logic [4:0]                   rf_waddr,
  output logic [31:0]                  rf_wdata,
  output logic [WS_FWD_BLK_BUS_WD-1:0] ws_fwd_blk_bus,
  output logic                         ws_inst_mfc0_o,
  output logic                         ws_ex,
  output logic                         ws_eret,
  output logic [31:0]                  ws_redirect_pc,
  output logic                         ws_int_pending,
  output logic [31:0]                  debug_wb_pc,
  output logic [3:0]                   debug_wb_rf_wen,
  output logic [4:0]                   debug_wb_rf_wnum,
  output logic [31:0]                  debug_wb_rf_wdata
);

  logic      ws_valid_q, ws_valid_d;
  ms_to_ws_t bus_q, bus_d;
  logic      ready_go;
  logic      commit;
  logic      cp0_we;
  logic      ex_commit;
  logic      eret_commit;
  logic [31:0] cp0_rdata;
  logic [31:0] cp0_epc;
  logic      unused_syscall;

  // Handshake and pipeline-register next state
  always_comb begin
    ready_go   = 1'b1;
    ws_allowin = ~ws_valid_q | ready_go;
    ws_valid_d = ws_allowin ? ms_to_ws_valid : ws_valid_q;
    bus_d      = (ms_to_ws_valid & ws_allowin) ? ms_to_ws_t'(ms_to_ws_bus) : bus_q;
  end

  // Pipeline register
  always_ff @(posedge clk) begin
    if (reset) begin
      ws_valid_q <= 1'b0;
      bus_q      <= '0;
    end else begin
      ws_valid_q <= ws_valid_d;
      bus_q      <= bus_d;
    end
  end

  // Commit qualifiers; reset gates commit so an in-flight instruction is dropped
  always_comb begin
    commit         = ws_valid_q & ~reset;
    ex_commit      = commit & bus_q.ex;
    eret_commit    = commit & bus_q.eret & ~bus_q.ex;
    cp0_we         = commit & bus_q.mtc0 & ~bus_q.ex;
    unused_syscall = bus_q.syscall;
  end

  cp0_regs #(
    .INT_WIDTH(INT_WIDTH)
  ) u_cp0 (
    .clk          (clk),
    .reset        (reset),
    .mtc0_we_i    (cp0_we),
    .addr_i       (bus_q.cp0_addr),
    .wdata_i      (bus_q.result),
    .rdata_o      (cp0_rdata),
    .ex_i         (ex_commit),
    .excode_i     (bus_q.excode),
    .bd_i         (bus_q.bd),
    .pc_i         (bus_q.pc),
    .badvaddr_i   (bus_q.badvaddr),
    .eret_i       (eret_commit),
    .ext_int_i    (ext_int_in),
    .epc_o        (cp0_epc),
    .int_pending_o(ws_int_pending)
  );

  // Register-file, forward, flush and trace outputs
  always_comb begin
    rf_we             = {4{commit & ~bus_q.ex}} & bus_q.gr_strb;
    rf_waddr          = bus_q.dest;
    rf_wdata          = bus_q.mfc0 ? cp0_rdata : bus_q.result;
    ws_fwd_blk_bus    = {rf_we, rf_waddr, rf_wdata};
    ws_inst_mfc0_o    = commit & bus_q.mfc0;
    ws_ex             = ex_commit;
    ws_eret           = eret_commit;
    ws_redirect_pc    = ex_commit ? EX_ENTRY : cp0_epc;
    debug_wb_pc       = bus_q.pc;
    debug_wb_rf_wen   = rf_we;
    debug_wb_rf_wnum  = rf_waddr;
    debug_wb_rf_wdata = rf_wdata;
  end

endmodule
